traffic_light_monitor: RTL and testbench

- Observer for a two-way junction light controller. Samples the lightsA/lightsB 3-bit light codes from the controller.
- Recovers the controller's 8-phase position and flags safety conflicts and illegal sequences (both sticky).
- Counts completed light cycles.
- Sits on the controller's outputs as an in-system checker and as the bench scoreboard front end.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/traffic_light_monitor_if.sv | 26 ++
 rtl/traffic_phase_decode.sv | 32 +++
 rtl/traffic_light_monitor.sv | 100 ++++++++++
 tb/tb_traffic_light_monitor.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes and phase table for the two-way junction controller,
// its in-system monitor and the bench.
package traffic_pkg;

  typedef logic [2:0] phase_t;

  localparam logic [2:0] LIGHT_R  = 3'b100;
  localparam logic [2:0] LIGHT_RA = 3'b110;
  localparam logic [2:0] LIGHT_G  = 3'b001;
  localparam logic [2:0] LIGHT_A  = 3'b010;

  // Returns the {A,B} light pair the controller drives in phase p.
  function automatic logic [5:0] phase_lights(input phase_t p);
    logic [5:0] pair;
    case (p)
      3'd0:    pair = {LIGHT_R,  LIGHT_RA};
      3'd1:    pair = {LIGHT_R,  LIGHT_G};
      3'd2:    pair = {LIGHT_R,  LIGHT_A};
      3'd3:    pair = {LIGHT_R,  LIGHT_R};
      3'd4:    pair = {LIGHT_RA, LIGHT_R};
      3'd5:    pair = {LIGHT_G,  LIGHT_R};
      3'd6:    pair = {LIGHT_A,  LIGHT_R};
      default: pair = {LIGHT_R,  LIGHT_R};
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light-code and status bundle between a junction controller and its monitor.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  import traffic_pkg::*;

  logic [2:0]       lightsA;
  logic [2:0]       lightsB;
  logic             err_clr;
  logic             locked;
  phase_t           phase;
  logic             conflict;
  logic             seq_err;
  logic [CNT_W-1:0] cycles;

  modport master (
    output lightsA, lightsB, err_clr,
    input  locked, phase, conflict, seq_err, cycles
  );

  modport slave (
    input  lightsA, lightsB, err_clr,
    output locked, phase, conflict, seq_err, cycles
  );

endinterface

// File: rtl/traffic_phase_decode.sv
// Combinational classifier for one sampled {A,B} light pair: table membership,
// the (R,R) ambiguity, conflict, and the phase for unambiguous pairs.
module traffic_phase_decode
  import traffic_pkg::*;
(
  input  logic [2:0] lights_a_i,
  input  logic [2:0] lights_b_i,
  output logic       legal_o,
  output logic       ambiguous_o,
  output logic       conflict_o,
  output phase_t     phase_o
);

  logic [5:0] pair;

  assign pair        = {lights_a_i, lights_b_i};
  assign ambiguous_o = (pair == {LIGHT_R, LIGHT_R});
  assign conflict_o  = (lights_a_i != LIGHT_R) && (lights_b_i != LIGHT_R);

  // First match wins, so (R,R) decodes as 3; callers treat it as ambiguous.
  always_comb begin
    legal_o = 1'b0;
    phase_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (!legal_o && (pair == phase_lights(phase_t'(i[2:0])))) begin
        legal_o = 1'b1;
        phase_o = phase_t'(i[2:0]);
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Observer for a two-way junction light controller: recovers the 8-phase
// position, flags sticky conflicts / sequence errors and counts full cycles.
//
// state  | meaning
// HUNT   | not tracking; waiting for an unambiguous table pair to lock on
// LOCKED | tracking; every sample must equal the table entry for exp_q
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q;
  logic             locked_q;
  phase_t           phase_q;
  phase_t           exp_q;
  logic             conflict_q;
  logic             seq_err_q;
  logic [CNT_W-1:0] cycles_q;

  logic             dec_legal;
  logic             dec_ambig;
  logic             dec_conflict;
  phase_t           dec_phase;
  logic             exp_match;
  logic             seq_err_new;
  logic             conflict_d;
  logic             seq_err_d;
  logic [CNT_W-1:0] cycles_d;

  traffic_phase_decode u_decode (
    .lights_a_i  (mon.lightsA),
    .lights_b_i  (mon.lightsB),
    .legal_o     (dec_legal),
    .ambiguous_o (dec_ambig),
    .conflict_o  (dec_conflict),
    .phase_o     (dec_phase)
  );

  assign exp_match   = ({mon.lightsA, mon.lightsB} == phase_lights(exp_q));
  assign seq_err_new = (state_q == HUNT) ? !dec_legal : !exp_match;

  // A fresh error on the same sample as err_clr keeps the flag set.
  assign conflict_d = dec_conflict | (conflict_q & ~mon.err_clr);
  assign seq_err_d  = seq_err_new  | (seq_err_q  & ~mon.err_clr);
  assign cycles_d   = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      locked_q   <= 1'b0;
      phase_q    <= '0;
      exp_q      <= '0;
      conflict_q <= 1'b0;
      seq_err_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      seq_err_q  <= seq_err_d;
      case (state_q)
        HUNT: begin
          if (dec_legal && !dec_ambig) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            phase_q  <= dec_phase;
            exp_q    <= dec_phase + 3'd1;
          end
        end
        LOCKED: begin
          if (exp_match) begin
            phase_q <= exp_q;
            exp_q   <= exp_q + 3'd1;
            if (exp_q == 3'd0) cycles_q <= cycles_d;
          end else begin
            // The offending sample is not reused; relock starts next sample.
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon.locked   = locked_q;
  assign mon.phase    = phase_q;
  assign mon.conflict = conflict_q;
  assign mon.seq_err  = seq_err_q;
  assign mon.cycles   = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: an 8-bit-counter instance and a
// 2-bit-counter instance see identical stimulus and are checked per scenario.
module tb_traffic_light_monitor;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RA = 3'b110;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] A  = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [2:0] ta [8];
  logic [2:0] tb [8];

  traffic_light_monitor_if #(.CNT_W(8)) m8 ();
  traffic_light_monitor_if #(.CNT_W(2)) m2 ();

  traffic_light_monitor #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .mon(m8));
  traffic_light_monitor #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .mon(m2));

  always #5 clk = ~clk;

  // Drive one sample, let it be clocked in, then settle past the edge.
  task automatic step(input logic [2:0] a, input logic [2:0] b,
                      input logic clr, input logic r);
    @(negedge clk);
    m8.lightsA = a; m8.lightsB = b; m8.err_clr = clr;
    m2.lightsA = a; m2.lightsB = b; m2.err_clr = clr;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(R, R, 1'b0, 1'b1);
    step(R, R, 1'b0, 1'b1);
    n_cmp++; if (m8.locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b want 0", m8.locked); end
    n_cmp++; if (m8.phase !== 3'd0) begin n_fail++; $display("FAIL rst_phase got %0d want 0", m8.phase); end
    n_cmp++; if (m8.conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conflict got %b want 0", m8.conflict); end
    n_cmp++; if (m8.seq_err !== 1'b0) begin n_fail++; $display("FAIL rst_seq_err got %b want 0", m8.seq_err); end
    n_cmp++; if (m8.cycles !== 8'd0) begin n_fail++; $display("FAIL rst_cycles got %0d want 0", m8.cycles); end
  endtask

  task automatic test_full_cycle();
    step(R, R, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step(ta[k % 8], tb[k % 8], 1'b0, 1'b0);
      n_cmp++; if (m8.locked !== 1'b1) begin n_fail++; $display("FAIL cyc_locked k=%0d got %b want 1", k, m8.locked); end
      n_cmp++; if (m8.phase !== 3'(k % 8)) begin n_fail++; $display("FAIL cyc_phase k=%0d got %0d want %0d", k, m8.phase, k % 8); end
      n_cmp++; if ({m8.conflict, m8.seq_err} !== 2'b00) begin n_fail++; $display("FAIL cyc_flags k=%0d got %b want 00", k, {m8.conflict, m8.seq_err}); end
      n_cmp++; if (m8.cycles !== ((k == 8) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL cyc_count k=%0d got %0d want %0d", k, m8.cycles, (k == 8) ? 1 : 0); end
    end
  endtask

  task automatic test_hunt_rr();
    step(R, R, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(R, R, 1'b0, 1'b0);
      n_cmp++; if ({m8.locked, m8.seq_err} !== 2'b00) begin n_fail++; $display("FAIL rr_hold k=%0d got %b want 00", k, {m8.locked, m8.seq_err}); end
    end
    step(R, G, 1'b0, 1'b0);
    n_cmp++; if (m8.locked !== 1'b1) begin n_fail++; $display("FAIL rr_lock got %b want 1", m8.locked); end
    n_cmp++; if (m8.phase !== 3'd1) begin n_fail++; $display("FAIL rr_phase got %0d want 1", m8.phase); end
    n_cmp++; if (m8.seq_err !== 1'b0) begin n_fail++; $display("FAIL rr_seq_err got %b want 0", m8.seq_err); end
  endtask

  // Continues from test_hunt_rr: locked at phase 1.
  task automatic test_mismatch();
    step(RA, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.locked, m8.seq_err} !== 2'b01) begin n_fail++; $display("FAIL mis_drop got %b want 01", {m8.locked, m8.seq_err}); end
    n_cmp++; if (m8.phase !== 3'd1) begin n_fail++; $display("FAIL mis_phase_hold got %0d want 1", m8.phase); end
    n_cmp++; if (m8.conflict !== 1'b0) begin n_fail++; $display("FAIL mis_conflict got %b want 0", m8.conflict); end
    step(G, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.locked, m8.phase, m8.seq_err} !== {1'b1, 3'd5, 1'b1}) begin n_fail++; $display("FAIL mis_relock5 got %b want 11011", {m8.locked, m8.phase, m8.seq_err}); end
    step(A, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.locked, m8.phase, m8.seq_err} !== {1'b1, 3'd6, 1'b1}) begin n_fail++; $display("FAIL mis_track6 got %b want 11101", {m8.locked, m8.phase, m8.seq_err}); end
  endtask

  task automatic test_conflict();
    step(R, R, 1'b0, 1'b1);
    step(R, RA, 1'b0, 1'b0);
    step(G, G, 1'b0, 1'b0);
    n_cmp++; if ({m8.conflict, m8.seq_err, m8.locked} !== 3'b110) begin n_fail++; $display("FAIL cf_set got %b want 110", {m8.conflict, m8.seq_err, m8.locked}); end
    step(R, R, 1'b1, 1'b0);
    n_cmp++; if ({m8.conflict, m8.seq_err} !== 2'b00) begin n_fail++; $display("FAIL cf_clear got %b want 00", {m8.conflict, m8.seq_err}); end
    n_cmp++; if ({m8.locked, m8.phase} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL cf_clr_side got %b want 0000", {m8.locked, m8.phase}); end
    step(3'b111, 3'b111, 1'b1, 1'b0);
    n_cmp++; if (m8.seq_err !== 1'b1) begin n_fail++; $display("FAIL cf_set_wins got %b want 1", m8.seq_err); end
    n_cmp++; if (m8.conflict !== 1'b1) begin n_fail++; $display("FAIL cf_111_conflict got %b want 1", m8.conflict); end
    step(R, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.conflict, m8.seq_err} !== 2'b11) begin n_fail++; $display("FAIL cf_sticky got %b want 11", {m8.conflict, m8.seq_err}); end
  endtask

  task automatic test_back_to_back();
    step(R, R, 1'b0, 1'b1);
    step(G, R, 1'b0, 1'b0);
    step(G, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.locked, m8.seq_err} !== 2'b01) begin n_fail++; $display("FAIL hold_legal got %b want 01", {m8.locked, m8.seq_err}); end
    step(R, R, 1'b0, 1'b1);
    step(R, A, 1'b0, 1'b0);
    step(R, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.locked, m8.phase, m8.seq_err} !== {1'b1, 3'd3, 1'b0}) begin n_fail++; $display("FAIL rr_track3 got %b want 10110", {m8.locked, m8.phase, m8.seq_err}); end
    step(R, R, 1'b0, 1'b0);
    n_cmp++; if ({m8.locked, m8.seq_err} !== 2'b01) begin n_fail++; $display("FAIL rr_repeat got %b want 01", {m8.locked, m8.seq_err}); end
  endtask

  task automatic test_saturate();
    step(R, R, 1'b0, 1'b1);
    for (int k = 0; k < 41; k++) step(ta[k % 8], tb[k % 8], 1'b0, 1'b0);
    n_cmp++; if (m2.cycles !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2 got %0d want 3", m2.cycles); end
    n_cmp++; if (m8.cycles !== 8'd5) begin n_fail++; $display("FAIL sat_cnt8 got %0d want 5", m8.cycles); end
    for (int k = 1; k < 5; k++) step(ta[k], tb[k], 1'b0, 1'b0);
    n_cmp++; if ({m2.locked, m2.phase} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL sat_pre_rst got %b want 1100", {m2.locked, m2.phase}); end
    step(G, R, 1'b0, 1'b1);
    n_cmp++; if ({m2.locked, m2.phase, m2.conflict, m2.seq_err, m2.cycles} !== 9'd0) begin n_fail++; $display("FAIL midrst_2 got %b want 0", {m2.locked, m2.phase, m2.conflict, m2.seq_err, m2.cycles}); end
    n_cmp++; if ({m8.locked, m8.phase, m8.cycles} !== 12'd0) begin n_fail++; $display("FAIL midrst_8 got %b want 0", {m8.locked, m8.phase, m8.cycles}); end
    step(R, R, 1'b0, 1'b0);
    n_cmp++; if (m2.locked !== 1'b0) begin n_fail++; $display("FAIL post_rst_rr got %b want 0", m2.locked); end
    step(A, R, 1'b0, 1'b0);
    n_cmp++; if ({m2.locked, m2.phase, m2.seq_err} !== {1'b1, 3'd6, 1'b0}) begin n_fail++; $display("FAIL post_rst_lock got %b want 11100", {m2.locked, m2.phase, m2.seq_err}); end
  endtask

  initial begin
    ta = '{R,  R, R, R, RA, G, A, R};
    tb = '{RA, G, A, R, R,  R, R, R};
    m8.lightsA = R; m8.lightsB = R; m8.err_clr = 1'b0;
    m2.lightsA = R; m2.lightsB = R; m2.err_clr = 1'b0;
    test_reset();
    test_full_cycle();
    test_hunt_rr();
    test_mismatch();
    test_conflict();
    test_back_to_back();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
